weight_fifo_ctrl: RTL and testbench
===================================

// Module: weight_fifo_ctrl
// PURPOSE
//  Sequencer for the systolic-array weight FIFO (FIFO_INPUTS columns x FIFO_DEPTH stages).
//  - Fill: reads FIFO_DEPTH weight rows from weight memory and pushes them into the FIFO.
//  - Drain: shifts the stored rows out into the array, feeding zeros in behind them.
//  - Sits between the top-level command decoder and weightFIFO; owns its per-column enables.
// PARAMETERS
//  FIFO_INPUTS  4  number of columns; width of fifo_en
//  FIFO_DEPTH   4  number of stages; rows per fill and per drain
//  ADDR_WIDTH   8  weight-memory address width
// PORTS
//  clk             in   1            rising-edge clock
//  reset           in   1            asynchronous, active-high reset
//  load_start      in   1            1-cycle pulse: start a fill
//  load_base_addr  in   ADDR_WIDTH   first row address; sampled with load_start
//  drain_start     in   1            1-cycle pulse: start a drain
//  mem_rd_en       out  1            weight-memory read strobe; data valid 1 cycle later
//  mem_rd_addr     out  ADDR_WIDTH   weight-memory row address
//  fifo_en         out  FIFO_INPUTS  per-column shift enable to the FIFO; bit i = column i
//  fifo_zero_in    out  1            1 = datapath muxes zeros onto FIFO weightIn
//  drain_valid     out  1            the row at FIFO weightOut is entering the array this cycle
//  fifo_full       out  1            FIFO_DEPTH valid rows held
//  busy            out  1            state is FILL or DRAIN
//  done            out  1            1-cycle pulse at the end of a fill or a drain
//  cmd_err         out  1            1-cycle pulse: a command was rejected
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately.
//    FIFO contents are not trusted afterwards (fifo_full=0).
//  - States: IDLE, FILL, FULL, DRAIN. busy=1 in FILL/DRAIN.
//  - Accepted commands:
//    - load_start is accepted in IDLE and in FULL (overwrite).
//    - drain_start is accepted in FULL only.
//  - Rejected commands (cmd_err pulses the next cycle, state unchanged):
//    - any command while busy;
//    - drain_start in IDLE.
//  - load_start and drain_start in the same cycle:
//    - in IDLE: load wins, no cmd_err;
//    - in FULL: drain wins, load is rejected with cmd_err.
//  - FILL (load accepted at cycle 0):
//    - mem_rd_en=1 in cycles 1..D (D=FIFO_DEPTH).
//    - mem_rd_addr = base+k in cycle k+1; wraps modulo 2^ADDR_WIDTH.
//    - fifo_en = all ones in cycles 2..D+1 (registered read-valid, 1-cycle memory latency); fifo_zero_in=0.
//    - Cycle D+2: fifo_full=1, done pulse, state=FULL.
//    - On an overwrite from FULL, fifo_full drops at cycle 1.
//  - FULL: fifo_en=0; outputs hold; waits indefinitely.
//  - DRAIN (drain accepted at cycle 0):
//    - fifo_full=0 from cycle 1; fifo_zero_in=1 for the whole drain.
//    - fifo_en = all ones and drain_valid=1 in cycles 1..D.
//    - Cycle D+1: done pulse, state=IDLE.
//  - Rows leave in fill order: the first row read is the first drained.
//  - Counters: row counter of $clog2(FIFO_DEPTH+1) bits, cleared on each state entry.
//    mem_rd_addr is a registered ADDR_WIDTH adder.
// CONFIGURATION
//  WEIGHT_SKEW_EN
//    - Defined: drain enables are diagonally skewed.
//      - fifo_en[i] is high in cycles 1+i..D+i.
//      - Drain length is D+FIFO_INPUTS-1 cycles; done pulses at cycle D+FIFO_INPUTS.
//      - drain_valid = OR of fifo_en.
//    - Undefined: all columns shift together as described in BEHAVIOUR. Fill is identical in both builds.
// TESTING
//  - Reset check: assert reset async mid-cycle during FILL -> all outputs 0 immediately, state IDLE.
//  - Fill, D=4, base=0x10:
//    - mem_rd_addr 0x10..0x13 in cycles 1..4;
//    - fifo_en=4'hF in cycles 2..5;
//    - fifo_full and done at cycle 6.
//  - Address wrap: base=0xFE, D=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
//  - Drain after fill:
//    - fifo_en=4'hF and drain_valid in cycles 1..4; fifo_zero_in=1;
//    - done at 5; the row from 0x10 appears first.
//  - Illegal commands:
//    - drain_start in IDLE -> cmd_err.
//    - load_start during FILL -> cmd_err; fill completes unchanged.
//    - Both commands in FULL -> drain runs, cmd_err.
//  - WEIGHT_SKEW_EN, D=4, INPUTS=4:
//    - fifo_en: cycle1=0001, 2=0011, 3=0111, 4=1111, 5=1110, 6=1100, 7=1000;
//    - done at cycle 8.

Source files
------------

// File: rtl/weight_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : weight_fifo_ctrl
// Description : Sequencer for the systolic-array weight FIFO. A fill reads
//               FIFO_DEPTH weight rows from weight memory and pushes them into
//               the FIFO. A drain shifts the stored rows out into the array and
//               feeds zeros in behind them. Illegal commands pulse cmd_err.
// Options     : WEIGHT_SKEW_EN - when defined, drain enables are diagonally
//               skewed so column i shifts i cycles after column 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module weight_fifo_ctrl #(
  parameter int FIFO_INPUTS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load_start,
  input  logic [ADDR_WIDTH-1:0]  i_load_base_addr,
  input  logic                   i_drain_start,
  output logic                   o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_mem_rd_addr,
  output logic [FIFO_INPUTS-1:0] o_fifo_en,
  output logic                   o_fifo_zero_in,
  output logic                   o_drain_valid,
  output logic                   o_fifo_full,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_cmd_err
);

  // Number of cycles the drain keeps the FSM busy.
`ifdef WEIGHT_SKEW_EN
  localparam int c_DRAIN_LEN = FIFO_DEPTH + FIFO_INPUTS - 1;
`else
  localparam int c_DRAIN_LEN = FIFO_DEPTH;
`endif

  // The counter must reach FIFO_DEPTH during a fill and c_DRAIN_LEN-1 during
  // a drain; size it for whichever is larger.
  localparam int c_CNT_MAX = (c_DRAIN_LEN > FIFO_DEPTH) ? c_DRAIN_LEN : FIFO_DEPTH;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_nxt_cnt;

  logic                   r_mem_rd_en;
  logic [ADDR_WIDTH-1:0]  r_mem_rd_addr;
  logic [FIFO_INPUTS-1:0] r_fifo_en;
  logic                   r_fifo_zero_in;
  logic                   r_drain_valid;
  logic                   r_fifo_full;
  logic                   r_done;
  logic                   r_cmd_err;

  logic                   w_nxt_rd_en;
  logic [ADDR_WIDTH-1:0]  w_nxt_rd_addr;
  logic [FIFO_INPUTS-1:0] w_nxt_fifo_en;
  logic                   w_nxt_zero_in;
  logic                   w_nxt_drain_valid;
  logic                   w_nxt_fifo_full;
  logic                   w_nxt_done;
  logic                   w_nxt_cmd_err;
  int                     w_drain_cyc;

  // Column enables for drain cycle n (n = 1 is the first drain cycle).
  function automatic logic [FIFO_INPUTS-1:0] f_drain_en(input int n);
    logic [FIFO_INPUTS-1:0] en;
    en = '0;
    for (int i = 0; i < FIFO_INPUTS; i++) begin
`ifdef WEIGHT_SKEW_EN
      en[i] = (n >= 1 + i) && (n <= FIFO_DEPTH + i);
`else
      en[i] = (n >= 1) && (n <= FIFO_DEPTH);
`endif
    end
    return en;
  endfunction

  // State and cycle counter registers; reset aborts any operation at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next-state decode plus the next value of every registered output.
  // Counter value k in FILL/DRAIN means the FSM is in cycle k+1 of that phase.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = '0;
    w_nxt_rd_en       = 1'b0;
    w_nxt_rd_addr     = r_mem_rd_addr;
    w_nxt_fifo_en     = '0;
    w_nxt_zero_in     = 1'b0;
    w_nxt_drain_valid = 1'b0;
    w_nxt_fifo_full   = r_fifo_full;
    w_nxt_done        = 1'b0;
    w_nxt_cmd_err     = 1'b0;
    w_drain_cyc       = 0;

    case (r_state)
      S_IDLE: begin
        if (i_load_start) begin
          // Load wins over a simultaneous drain; no error in IDLE.
          w_nxt_state     = S_FILL;
          w_nxt_rd_en     = 1'b1;
          w_nxt_rd_addr   = i_load_base_addr;
          w_nxt_fifo_full = 1'b0;
        end else if (i_drain_start) begin
          w_nxt_cmd_err = 1'b1;
        end
      end

      S_FILL: begin
        w_nxt_cnt     = r_cnt + c_CNT_W'(1);
        w_nxt_cmd_err = i_load_start | i_drain_start;
        // Memory data arrives one cycle after the read strobe, so the push
        // enable is simply the read strobe delayed by one cycle.
        w_nxt_fifo_en = {FIFO_INPUTS{r_mem_rd_en}};
        if (r_cnt < c_CNT_W'(FIFO_DEPTH - 1)) begin
          w_nxt_rd_en   = 1'b1;
          w_nxt_rd_addr = r_mem_rd_addr + ADDR_WIDTH'(1);
        end
        if (r_cnt == c_CNT_W'(FIFO_DEPTH)) begin
          w_nxt_state     = S_FULL;
          w_nxt_cnt       = '0;
          w_nxt_fifo_full = 1'b1;
          w_nxt_done      = 1'b1;
        end
      end

      S_FULL: begin
        if (i_drain_start) begin
          // Drain wins; a simultaneous load is rejected.
          w_nxt_state       = S_DRAIN;
          w_nxt_fifo_full   = 1'b0;
          w_nxt_zero_in     = 1'b1;
          w_nxt_fifo_en     = f_drain_en(1);
          w_nxt_drain_valid = |f_drain_en(1);
          w_nxt_cmd_err     = i_load_start;
        end else if (i_load_start) begin
          // Overwrite: the stored rows are discarded as soon as the fill starts.
          w_nxt_state     = S_FILL;
          w_nxt_rd_en     = 1'b1;
          w_nxt_rd_addr   = i_load_base_addr;
          w_nxt_fifo_full = 1'b0;
        end
      end

      S_DRAIN: begin
        w_nxt_cnt     = r_cnt + c_CNT_W'(1);
        w_nxt_cmd_err = i_load_start | i_drain_start;
        if (r_cnt == c_CNT_W'(c_DRAIN_LEN - 1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
          w_nxt_done  = 1'b1;
        end else begin
          w_drain_cyc       = int'(r_cnt) + 2;
          w_nxt_zero_in     = 1'b1;
          w_nxt_fifo_en     = f_drain_en(w_drain_cyc);
          w_nxt_drain_valid = |f_drain_en(w_drain_cyc);
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Output registers; the FIFO contents are untrusted after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd_en    <= 1'b0;
      r_mem_rd_addr  <= '0;
      r_fifo_en      <= '0;
      r_fifo_zero_in <= 1'b0;
      r_drain_valid  <= 1'b0;
      r_fifo_full    <= 1'b0;
      r_done         <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_mem_rd_en    <= w_nxt_rd_en;
      r_mem_rd_addr  <= w_nxt_rd_addr;
      r_fifo_en      <= w_nxt_fifo_en;
      r_fifo_zero_in <= w_nxt_zero_in;
      r_drain_valid  <= w_nxt_drain_valid;
      r_fifo_full    <= w_nxt_fifo_full;
      r_done         <= w_nxt_done;
      r_cmd_err      <= w_nxt_cmd_err;
    end
  end

  assign o_mem_rd_en    = r_mem_rd_en;
  assign o_mem_rd_addr  = r_mem_rd_addr;
  assign o_fifo_en      = r_fifo_en;
  assign o_fifo_zero_in = r_fifo_zero_in;
  assign o_drain_valid  = r_drain_valid;
  assign o_fifo_full    = r_fifo_full;
  assign o_busy         = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign o_done         = r_done;
  assign o_cmd_err      = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_weight_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_weight_fifo_ctrl
// Description : Self-checking bench for weight_fifo_ctrl. A timeline model
//               predicts every output per cycle, a per-column FIFO model with
//               a synthetic weight memory checks drain row order, and directed
//               sequences pin literal expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_weight_fifo_ctrl;

  localparam int FI = 4;
  localparam int FD = 4;
  localparam int AW = 8;
`ifdef WEIGHT_SKEW_EN
  localparam int DL = FD + FI - 1;
  localparam bit SKEW = 1'b1;
`else
  localparam int DL = FD;
  localparam bit SKEW = 1'b0;
`endif
  localparam int MI = 0, MF = 1, MU = 2, MD = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld, dr;
  logic [AW-1:0] base;
  logic          o_rd;
  logic [AW-1:0] o_addr;
  logic [FI-1:0] o_en;
  logic          o_zero, o_valid, o_full, o_busy, o_done, o_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  weight_fifo_ctrl #(.FIFO_INPUTS(FI), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .i_load_start(ld), .i_load_base_addr(base), .i_drain_start(dr),
    .o_mem_rd_en(o_rd), .o_mem_rd_addr(o_addr), .o_fifo_en(o_en),
    .o_fifo_zero_in(o_zero), .o_drain_valid(o_valid), .o_fifo_full(o_full),
    .o_busy(o_busy), .o_done(o_done), .o_cmd_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synthetic weight memory: column col of row a.
  function automatic logic [7:0] memv(input logic [AW-1:0] a, input int col);
    int v;
    v = int'(a) * 7 + col * 31 + 1;
    return v[7:0];
  endfunction

  // ---------------- timeline model ----------------
  int          m_mode;
  int          m_t;
  logic [AW-1:0] m_base;
  bit          m_err, m_done, m_rows_ok;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = MI; m_t = 0; m_err = 0; m_done = 0; m_rows_ok = 0;
    end else begin
      m_err = 0; m_done = 0;
      case (m_mode)
        MI: if (ld) begin m_mode = MF; m_t = 1; m_base = base; end
            else if (dr) m_err = 1;
        MF: begin
          m_err = ld | dr;
          if (m_t == FD + 1) begin m_mode = MU; m_done = 1; m_rows_ok = 1; end
          else m_t++;
        end
        MU: if (dr) begin m_mode = MD; m_t = 1; m_err = ld; end
            else if (ld) begin m_mode = MF; m_t = 1; m_base = base; m_rows_ok = 0; end
        default: begin
          m_err = ld | dr;
          if (m_t == DL) begin m_mode = MI; m_done = 1; m_rows_ok = 0; end
          else m_t++;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + FIFO row-order model ----------------
  logic [7:0] q [FI][FD];
  int         pops [FI];
  bit         prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin : b_cmp
    logic [FI-1:0] e_en;
    logic [7:0]    outv, inv;
    if (chk_on) begin
      e_en = '0;
      if (m_mode == MF && m_t >= 2) e_en = '1;
      if (m_mode == MD)
        for (int i = 0; i < FI; i++)
          e_en[i] = SKEW ? (m_t >= 1 + i && m_t <= FD + i) : (m_t <= FD);
      chk("rd_en",   32'(o_rd),    32'(m_mode == MF && m_t <= FD));
      if (m_mode == MF && m_t <= FD)
        chk("rd_addr", 32'(o_addr), 32'(AW'(m_base + AW'(m_t - 1))));
      if (reset) chk("rst_addr", 32'(o_addr), 32'd0);
      chk("fifo_en",   32'(o_en),    32'(e_en));
      chk("zero_in",   32'(o_zero),  32'(m_mode == MD));
      chk("drain_val", 32'(o_valid), 32'(m_mode == MD && e_en != '0));
      chk("full",      32'(o_full),  32'(m_mode == MU));
      chk("busy",      32'(o_busy),  32'(m_mode == MF || m_mode == MD));
      chk("done",      32'(o_done),  32'(m_done));
      chk("cmd_err",   32'(o_err),   32'(m_err));

      if (m_mode == MD && m_t == 1)
        for (int i = 0; i < FI; i++) pops[i] = 0;
      for (int i = 0; i < FI; i++) begin
        if (o_en[i]) begin
          outv = q[i][FD-1];
          if (m_mode == MD && m_rows_ok) begin
            chk("row_order", 32'(outv), 32'(memv(AW'(m_base + AW'(pops[i])), i)));
            pops[i]++;
          end
          inv = (o_zero || !prev_rd) ? 8'h00 : memv(prev_addr, i);
          for (int s = FD - 1; s > 0; s--) q[i][s] = q[i][s-1];
          q[i][0] = inv;
        end
      end
    end
    prev_rd   = o_rd;
    prev_addr = o_addr;
  end

  // ---------------- directed stimulus helpers ----------------
  logic          lg_rd   [16];
  logic [AW-1:0] lg_addr [16];
  logic [FI-1:0] lg_en   [16];
  logic          lg_zero [16], lg_valid [16], lg_full [16], lg_busy [16], lg_done [16], lg_err [16];

  // Issue a command in the current cycle (cycle 0) and log cycles 1..n.
  task automatic cmd_log(input logic l, input logic [AW-1:0] b, input logic d, input int n);
    ld = l; base = b; dr = d;
    @(posedge clk); #1;
    ld = 0; dr = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      lg_rd[c] = o_rd; lg_addr[c] = o_addr; lg_en[c] = o_en; lg_zero[c] = o_zero;
      lg_valid[c] = o_valid; lg_full[c] = o_full; lg_busy[c] = o_busy;
      lg_done[c] = o_done; lg_err[c] = o_err;
      @(posedge clk); #1;
    end
  endtask

  logic [FI-1:0] sk_tab [1:7];

  initial begin
    ld = 0; dr = 0; base = '0;
    sk_tab[1] = 4'b0001; sk_tab[2] = 4'b0011; sk_tab[3] = 4'b0111; sk_tab[4] = 4'b1111;
    sk_tab[5] = 4'b1110; sk_tab[6] = 4'b1100; sk_tab[7] = 4'b1000;
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outs", 32'({o_rd, o_addr, o_en, o_zero, o_valid, o_full, o_busy, o_done, o_err}), 32'd0);

    // Fill from 0x10.
    cmd_log(1, 8'h10, 0, 6);
    for (int c = 1; c <= 4; c++) begin
      chk("fill_rd", 32'(lg_rd[c]), 32'd1);
      chk("fill_addr", 32'(lg_addr[c]), 32'(8'h10 + c - 1));
    end
    chk("fill_rd5", 32'(lg_rd[5]), 32'd0);
    chk("fill_en1", 32'(lg_en[1]), 32'h0);
    for (int c = 2; c <= 5; c++) chk("fill_en", 32'(lg_en[c]), 32'hF);
    chk("fill_done5", 32'(lg_done[5]), 32'd0);
    chk("fill_full6", 32'(lg_full[6]), 32'd1);
    chk("fill_done6", 32'(lg_done[6]), 32'd1);

    // Drain after fill.
    cmd_log(0, 8'h00, 1, DL + 1);
`ifdef WEIGHT_SKEW_EN
    for (int c = 1; c <= 7; c++) chk("skew_en", 32'(lg_en[c]), 32'(sk_tab[c]));
    chk("skew_done8", 32'(lg_done[8]), 32'd1);
`else
    for (int c = 1; c <= 4; c++) begin
      chk("drain_en", 32'(lg_en[c]), 32'hF);
      chk("drain_valid", 32'(lg_valid[c]), 32'd1);
      chk("drain_zero", 32'(lg_zero[c]), 32'd1);
    end
    chk("drain_done5", 32'(lg_done[5]), 32'd1);
`endif
    chk("drain_full1", 32'(lg_full[1]), 32'd0);

    // Address wrap.
    cmd_log(1, 8'hFE, 0, 6);
    chk("wrap_a1", 32'(lg_addr[1]), 32'hFE);
    chk("wrap_a2", 32'(lg_addr[2]), 32'hFF);
    chk("wrap_a3", 32'(lg_addr[3]), 32'h00);
    chk("wrap_a4", 32'(lg_addr[4]), 32'h01);
    cmd_log(0, 8'h00, 1, DL + 1);

    // Drain in IDLE is rejected.
    cmd_log(0, 8'h00, 1, 1);
    chk("idle_drain_err", 32'(lg_err[1]), 32'd1);
    chk("idle_drain_busy", 32'(lg_busy[1]), 32'd0);

    // Load during FILL is rejected; the fill continues from the first base.
    cmd_log(1, 8'h20, 0, 1);
    cmd_log(1, 8'h55, 0, 5);
    chk("fill_load_err", 32'(lg_err[1]), 32'd1);
    chk("fill_keep_a3", 32'(lg_addr[1]), 32'h22);
    chk("fill_keep_a4", 32'(lg_addr[2]), 32'h23);
    chk("fill_keep_done", 32'(lg_done[4]), 32'd1);
    chk("fill_keep_full", 32'(lg_full[4]), 32'd1);

    // Both commands in FULL: drain runs, load rejected.
    cmd_log(1, 8'h77, 1, DL + 1);
    chk("both_err", 32'(lg_err[1]), 32'd1);
    chk("both_zero", 32'(lg_zero[1]), 32'd1);
    chk("both_busy", 32'(lg_busy[1]), 32'd1);
    chk("both_rd", 32'(lg_rd[1]), 32'd0);
    chk("both_done", 32'(lg_done[DL + 1]), 32'd1);

    // Asynchronous reset in the middle of a fill.
    cmd_log(1, 8'h40, 0, 2);
    #1 reset = 1'b1;
    #1 chk("async_rst", 32'({o_rd, o_addr, o_en, o_zero, o_valid, o_full, o_busy, o_done, o_err}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        ld = 0; dr = 0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end else begin
        ld   = ($urandom_range(0, 5) == 0);
        dr   = ($urandom_range(0, 3) == 0);
        base = AW'($urandom);
        @(posedge clk); #1;
      end
    end
    ld = 0; dr = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
